fp_sign_pipe: RTL

FP_SIGN_PIPE -- requirements
Module: fp_sign_pipe

---
 rtl/fp_sign_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fp_sign_pipe.sv
// Sign manipulation (abs / negate / pass / negative-abs) on LANES IEEE-754 words, with per-lane class flags and a NaN counter.
// Latency: LATENCY cycles from input transfer to output valid, one beat per cycle when the output is ready.
// Backpressure: every stage has its own valid bit; bubbles collapse; s_axis_a_tready is combinational from m_axis_result_tready.
module fp_sign_pipe #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 1,
  parameter int LATENCY   = 2,
  parameter int QUIET_NAN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_axis_a_tvalid,
  output logic                      s_axis_a_tready,
  input  logic [LANES*DATA_W-1:0]   s_axis_a_tdata,
  input  logic [1:0]                s_axis_a_tuser,
  input  logic                      s_axis_a_tlast,
  output logic                      m_axis_result_tvalid,
  input  logic                      m_axis_result_tready,
  output logic [LANES*DATA_W-1:0]   m_axis_result_tdata,
  output logic [3*LANES-1:0]        m_axis_result_tuser,
  output logic                      m_axis_result_tlast,
  output logic [31:0]               nan_count,
  input  logic                      nan_count_clr
);

  localparam int EXP_W  = (DATA_W == 64) ? 11 : 8;
  localparam int MAN_W  = DATA_W - 1 - EXP_W;
  localparam int BEAT_W = LANES * DATA_W;
  localparam int FLG_W  = 3 * LANES;
  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [BEAT_W-1:0] res_dat;
  logic [FLG_W-1:0]  res_flg;
  logic [LANES-1:0]  lane_nan;
  logic [3:0]        nan_beat;
  logic [32:0]       nan_sum;
  logic              in_xfer;

  // Per-lane datapath: classification is taken from the untouched input word.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] word;
    logic [EXP_W-1:0]  exp_f;
    logic [MAN_W-1:0]  man_f;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
    logic              sign_o;

    assign word    = s_axis_a_tdata[i*DATA_W +: DATA_W];
    assign exp_f   = word[DATA_W-2 -: EXP_W];
    assign man_f   = word[MAN_W-1:0];
    assign is_nan  = (&exp_f) & (|man_f);
    assign is_inf  = (&exp_f) & ~(|man_f);
    assign is_zero = ~(|exp_f) & ~(|man_f);

    // New sign bit according to the beat's op mode.
    always_comb begin
      sign_o = word[DATA_W-1];
      case (s_axis_a_tuser)
        2'b00:   sign_o = 1'b0;
        2'b01:   sign_o = ~word[DATA_W-1];
        2'b10:   sign_o = word[DATA_W-1];
        default: sign_o = 1'b1;
      endcase
    end

    assign res_dat[i*DATA_W +: DATA_W] = ((QUIET_NAN != 0) && is_nan) ? QNAN : {sign_o, exp_f, man_f};
    assign res_flg[3*i +: 3]           = {is_inf, is_zero, is_nan};
    assign lane_nan[i]                 = is_nan;
  end

  // Number of NaN lanes in the current input beat.
  always_comb begin
    nan_beat = '0;
    for (int i = 0; i < LANES; i++) begin
      nan_beat = nan_beat + 4'(lane_nan[i]);
    end
  end

  assign nan_sum = {1'b0, nan_count} + {29'd0, nan_beat};

  // Index 0 is the pipeline input, index k+1 is the output of stage k.
  logic [LATENCY:0]             p_vld;
  logic [LATENCY:0]             p_last;
  logic [LATENCY:0][BEAT_W-1:0] p_dat;
  logic [LATENCY:0][FLG_W-1:0]  p_flg;
  logic [LATENCY-1:0]           stg_ld;

  assign p_vld[0]  = s_axis_a_tvalid;
  assign p_last[0] = s_axis_a_tlast;
  assign p_dat[0]  = res_dat;
  assign p_flg[0]  = res_flg;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stg
    logic              vld;
    logic              last;
    logic [BEAT_W-1:0] dat;
    logic [FLG_W-1:0]  flg;

    // A stage may load when it or any later stage is empty, or the output is draining.
    assign stg_ld[k] = m_axis_result_tready | ~(&p_vld[LATENCY:k+1]);

    // Stage register: advance on load, clear everything on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld  <= 1'b0;
        last <= 1'b0;
        dat  <= '0;
        flg  <= '0;
      end else if (stg_ld[k]) begin
        vld  <= p_vld[k];
        last <= p_last[k];
        dat  <= p_dat[k];
        flg  <= p_flg[k];
      end
    end

    assign p_vld[k+1]  = vld;
    assign p_last[k+1] = last;
    assign p_dat[k+1]  = dat;
    assign p_flg[k+1]  = flg;
  end

  assign s_axis_a_tready      = stg_ld[0] & ~rst;
  assign in_xfer              = s_axis_a_tvalid & s_axis_a_tready;
  assign m_axis_result_tvalid = p_vld[LATENCY];
  assign m_axis_result_tlast  = p_last[LATENCY];
  assign m_axis_result_tdata  = p_dat[LATENCY];
  assign m_axis_result_tuser  = p_flg[LATENCY];

  // Saturating NaN counter; a clear coincident with a transfer keeps that beat's NaNs.
  always_ff @(posedge clk) begin
    if (rst) begin
      nan_count <= '0;
    end else if (nan_count_clr) begin
      nan_count <= in_xfer ? {28'd0, nan_beat} : 32'd0;
    end else if (in_xfer) begin
      nan_count <= nan_sum[32] ? 32'hFFFF_FFFF : nan_sum[31:0];
    end
  end

endmodule
